// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, the line/frame length helpers and the colour type.
package vga_pkg;

  localparam int unsigned DEF_HACTIVE = 640;
  localparam int unsigned DEF_HFP     = 16;
  localparam int unsigned DEF_HSYN    = 96;
  localparam int unsigned DEF_HBP     = 48;
  localparam int unsigned DEF_VACTIVE = 480;
  localparam int unsigned DEF_VFP     = 10;
  localparam int unsigned DEF_VSYN    = 2;
  localparam int unsigned DEF_VBP     = 33;

  // Counters are 10 bits wide, so a line or frame may hold at most this many steps.
  localparam int unsigned CNT_LIMIT = 1024;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  function automatic int unsigned calcHmax(input int unsigned active, input int unsigned fp,
                                           input int unsigned syn, input int unsigned bp);
    return active + fp + syn + bp;
  endfunction

  function automatic int unsigned calcVmax(input int unsigned active, input int unsigned fp,
                                           input int unsigned syn, input int unsigned bp);
    return active + fp + syn + bp;
  endfunction

endpackage

// File: rtl/vga_if.sv
// Bundle between the timing controller, the upstream pixel generator and the video DAC pins.
interface vga_if;
  import vga_pkg::*;

  rgb_t       rgb_in;
  logic [9:0] x;
  logic [9:0] y;
  logic       pix_en;
  logic       frame_start;
  logic       vgaclk;
  logic       hsync;
  logic       vsync;
  logic       sync_b;
  logic       blank_b;
  logic [7:0] r;
  logic [7:0] g;
  logic [7:0] b;

  modport master (
    input  rgb_in,
    output x, y, pix_en, frame_start,
    output vgaclk, hsync, vsync, sync_b, blank_b, r, g, b
  );

  modport slave (
    output rgb_in,
    input  x, y, pix_en, frame_start,
    input  vgaclk, hsync, vsync, sync_b, blank_b, r, g, b
  );
endinterface

// File: rtl/vga_pixel_div.sv
// Divides the system clock down to the pixel rate: pixel strobe plus a registered DAC clock.
module vga_pixel_div
  import vga_pkg::*;
#(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic reset,
  output logic o_pixEn,
  output logic o_vgaClk
);

  localparam int unsigned DCW = (DIV > 1) ? $clog2(DIV) : 1;

  if (DIV == 0 || DIV > 16) begin : gBadDiv
    $error("vga_pixel_div: DIV must be in 1..16");
  end

  logic [DCW-1:0] r_dcnt;
  logic           r_vgaClk;
  logic           w_last;
  logic [DCW-1:0] w_dcntNext;

  assign w_last     = (r_dcnt == DCW'(DIV - 1));
  assign w_dcntNext = w_last ? '0 : r_dcnt + 1'b1;

  // vgaClk is computed from the next divider value so the register tracks the current dcnt.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dcnt   <= '0;
      r_vgaClk <= 1'b1;
    end else begin
      r_dcnt   <= w_dcntNext;
      r_vgaClk <= (DIV == 1) ? 1'b1 : (w_dcntNext < DCW'(DIV / 2));
    end
  end

  assign o_pixEn  = w_last;
  assign o_vgaClk = r_vgaClk;

endmodule

// File: rtl/vga_controller.sv
// VGA timing generator: pixel/line counters plus a one-pixel-delayed, blanked DAC output stage.
module vga_controller
  import vga_pkg::*;
#(
  parameter int unsigned DIV     = 2,
  parameter int unsigned HACTIVE = DEF_HACTIVE,
  parameter int unsigned HFP     = DEF_HFP,
  parameter int unsigned HSYN    = DEF_HSYN,
  parameter int unsigned HBP     = DEF_HBP,
  parameter int unsigned VACTIVE = DEF_VACTIVE,
  parameter int unsigned VFP     = DEF_VFP,
  parameter int unsigned VSYN    = DEF_VSYN,
  parameter int unsigned VBP     = DEF_VBP
) (
  input logic  clk,
  input logic  reset,
  vga_if.master vga
);

  localparam int unsigned HMAX = calcHmax(HACTIVE, HFP, HSYN, HBP);
  localparam int unsigned VMAX = calcVmax(VACTIVE, VFP, VSYN, VBP);

  if (HMAX > CNT_LIMIT || VMAX > CNT_LIMIT || HMAX == 0 || VMAX == 0) begin : gBadTiming
    $error("vga_controller: HMAX and VMAX must be in 1..1024");
  end

  // 11-bit bounds so a region ending exactly at 1024 still compares correctly.
  localparam logic [10:0] H_ACT_END = 11'(HACTIVE);
  localparam logic [10:0] H_SYN_BEG = 11'(HACTIVE + HFP);
  localparam logic [10:0] H_SYN_END = 11'(HACTIVE + HFP + HSYN);
  localparam logic [10:0] V_ACT_END = 11'(VACTIVE);
  localparam logic [10:0] V_SYN_BEG = 11'(VACTIVE + VFP);
  localparam logic [10:0] V_SYN_END = 11'(VACTIVE + VFP + VSYN);

  logic       w_pixEn;
  logic       w_vgaClk;
  logic [9:0] r_hcnt;
  logic [9:0] r_vcnt;
  logic       r_frameStart;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_blankB;
  rgb_t       r_rgb;

  logic        w_hLast;
  logic        w_vLast;
  logic [10:0] w_hcntX;
  logic [10:0] w_vcntX;
  logic        w_hsyncNext;
  logic        w_vsyncNext;
  logic        w_blankBNext;

  vga_pixel_div #(.DIV(DIV)) uPixelDiv (
    .clk      (clk),
    .reset    (reset),
    .o_pixEn  (w_pixEn),
    .o_vgaClk (w_vgaClk)
  );

  assign w_hLast = (r_hcnt == 10'(HMAX - 1));
  assign w_vLast = (r_vcnt == 10'(VMAX - 1));
  assign w_hcntX = {1'b0, r_hcnt};
  assign w_vcntX = {1'b0, r_vcnt};

  assign w_hsyncNext  = !((w_hcntX >= H_SYN_BEG) && (w_hcntX < H_SYN_END));
  assign w_vsyncNext  = !((w_vcntX >= V_SYN_BEG) && (w_vcntX < V_SYN_END));
  assign w_blankBNext = (w_hcntX < H_ACT_END) && (w_vcntX < V_ACT_END);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hcnt       <= '0;
      r_vcnt       <= '0;
      r_frameStart <= 1'b0;
    end else begin
      r_frameStart <= w_pixEn && w_hLast && w_vLast;
      if (w_pixEn) begin
        if (w_hLast) begin
          r_hcnt <= '0;
          r_vcnt <= w_vLast ? '0 : r_vcnt + 1'b1;
        end else begin
          r_hcnt <= r_hcnt + 1'b1;
        end
      end
    end
  end

  // DAC stage samples the pre-edge counters, so it trails x/y by exactly one pixel period.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hsync  <= 1'b1;
      r_vsync  <= 1'b1;
      r_blankB <= 1'b0;
      r_rgb    <= '0;
    end else if (w_pixEn) begin
      r_hsync  <= w_hsyncNext;
      r_vsync  <= w_vsyncNext;
      r_blankB <= w_blankBNext;
      r_rgb    <= w_blankBNext ? vga.rgb_in : '0;
    end
  end

  assign vga.x           = r_hcnt;
  assign vga.y           = r_vcnt;
  assign vga.pix_en      = w_pixEn;
  assign vga.frame_start = r_frameStart;
  assign vga.vgaclk      = w_vgaClk;
  assign vga.hsync       = r_hsync;
  assign vga.vsync       = r_vsync;
  assign vga.sync_b      = 1'b0;
  assign vga.blank_b     = r_blankB;
  assign vga.r           = r_rgb.r;
  assign vga.g           = r_rgb.g;
  assign vga.b           = r_rgb.b;

endmodule

// File: tb/tb_vga_controller.sv
// Bench for vga_controller with shrunken timing, one instance at DIV=2 and one at DIV=1.
module tb_vga_controller;
  import vga_pkg::*;

  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 8,  VF = 2, VS = 2, VB = 2;
  localparam int HM = HA + HF + HS + HB;
  localparam int VM = VA + VF + VS + VB;
  localparam int FRAME = HM * VM;
  localparam int DIVA = 2;
  localparam int DIVB = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vga_if ifA();
  vga_if ifB();

  vga_controller #(.DIV(DIVA), .HACTIVE(HA), .HFP(HF), .HSYN(HS), .HBP(HB),
                   .VACTIVE(VA), .VFP(VF), .VSYN(VS), .VBP(VB))
    dutA (.clk(clk), .reset(reset), .vga(ifA));

  vga_controller #(.DIV(DIVB), .HACTIVE(HA), .HFP(HF), .HSYN(HS), .HBP(HB),
                   .VACTIVE(VA), .VFP(VF), .VSYN(VS), .VBP(VB))
    dutB (.clk(clk), .reset(reset), .vga(ifB));

  typedef struct {
    int x, y, pix, vclk, hs, vs, sb, bl, fs, rgb;
  } obs_t;

  typedef struct {
    int edges;
    int x, y, pix, vclk, hs, vs, bl, fs, rgb;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model: clk count since reset plus the output values captured at the last strobe.
  int          mCnt[2];
  logic        expHs[2];
  logic        expVs[2];
  logic        expBl[2];
  logic [23:0] expRgb[2];
  logic [23:0] curRgb[2];

  function automatic int divOf(input int d);
    return (d == 0) ? DIVA : DIVB;
  endfunction

  function automatic obs_t observe(input int d);
    obs_t o;
    if (d == 0) begin
      o.x = int'(ifA.x); o.y = int'(ifA.y); o.pix = int'(ifA.pix_en); o.vclk = int'(ifA.vgaclk);
      o.hs = int'(ifA.hsync); o.vs = int'(ifA.vsync); o.sb = int'(ifA.sync_b);
      o.bl = int'(ifA.blank_b); o.fs = int'(ifA.frame_start); o.rgb = int'({ifA.r, ifA.g, ifA.b});
    end else begin
      o.x = int'(ifB.x); o.y = int'(ifB.y); o.pix = int'(ifB.pix_en); o.vclk = int'(ifB.vgaclk);
      o.hs = int'(ifB.hsync); o.vs = int'(ifB.vsync); o.sb = int'(ifB.sync_b);
      o.bl = int'(ifB.blank_b); o.fs = int'(ifB.frame_start); o.rgb = int'({ifB.r, ifB.g, ifB.b});
    end
    return o;
  endfunction

  task automatic check(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, required, $time);
    end
  endtask

  task automatic modelEdge();
    for (int d = 0; d < 2; d++) begin
      int dv, p, h, v;
      dv = divOf(d);
      if (reset) begin
        mCnt[d] = 0; expHs[d] = 1'b1; expVs[d] = 1'b1; expBl[d] = 1'b0; expRgb[d] = '0;
      end else begin
        if (mCnt[d] % dv == dv - 1) begin
          p = mCnt[d] / dv;
          h = p % HM;
          v = (p / HM) % VM;
          expHs[d]  = !(h >= HA + HF && h < HA + HF + HS);
          expVs[d]  = !(v >= VA + VF && v < VA + VF + VS);
          expBl[d]  = (h < HA) && (v < VA);
          expRgb[d] = expBl[d] ? curRgb[d] : 24'h0;
        end
        mCnt[d]++;
      end
    end
  endtask

  task automatic tick();
    modelEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int mode);
    for (int d = 0; d < 2; d++) begin
      int p;
      p = mCnt[d] / divOf(d);
      case (mode)
        0:       curRgb[d] = 24'hFFAA55;
        1:       curRgb[d] = 24'($urandom);
        default: curRgb[d] = {8'(p % HM), 8'((p / HM) % VM), 8'h00};
      endcase
    end
    ifA.rgb_in = curRgb[0];
    ifB.rgb_in = curRgb[1];
  endtask

  task automatic checkOutput(input int d, input string tag);
    obs_t o;
    int dv, m, p;
    o  = observe(d);
    dv = divOf(d);
    m  = mCnt[d];
    p  = m / dv;
    check({tag, ".x"},      o.x,    p % HM);
    check({tag, ".y"},      o.y,    (p / HM) % VM);
    check({tag, ".pix_en"}, o.pix,  int'(m % dv == dv - 1));
    check({tag, ".vgaclk"}, o.vclk, (dv == 1) ? 1 : int'(m % dv < dv / 2));
    check({tag, ".frame"},  o.fs,   int'(m % dv == 0 && p > 0 && p % FRAME == 0));
    check({tag, ".hsync"},  o.hs,   int'(expHs[d]));
    check({tag, ".vsync"},  o.vs,   int'(expVs[d]));
    check({tag, ".sync_b"}, o.sb,   0);
    check({tag, ".blank"},  o.bl,   int'(expBl[d]));
    check({tag, ".rgb"},    o.rgb,  int'(expRgb[d]));
  endtask

  vec_t vecs[$];

  initial begin
    obs_t o;
    int   found;

    // Hand-derived checkpoints for DIV=2 with constant colour FFAA55 after reset release.
    vecs.push_back('{0,   0, 0,  0, 1, 1, 1, 0, 0, 0});
    vecs.push_back('{1,   0, 0,  1, 0, 1, 1, 0, 0, 0});
    vecs.push_back('{2,   1, 0,  0, 1, 1, 1, 1, 0, 'hFFAA55});
    vecs.push_back('{32,  16, 0, 0, 1, 1, 1, 1, 0, 'hFFAA55});
    vecs.push_back('{34,  17, 0, 0, 1, 1, 1, 0, 0, 0});
    vecs.push_back('{37,  18, 0, 1, 0, 1, 1, 0, 0, 0});
    vecs.push_back('{38,  19, 0, 0, 1, 0, 1, 0, 0, 0});
    vecs.push_back('{43,  21, 0, 1, 0, 0, 1, 0, 0, 0});
    vecs.push_back('{44,  22, 0, 0, 1, 1, 1, 0, 0, 0});
    vecs.push_back('{48,  0, 1,  0, 1, 1, 1, 0, 0, 0});
    vecs.push_back('{50,  1, 1,  0, 1, 1, 1, 1, 0, 'hFFAA55});
    vecs.push_back('{481, 0, 10, 1, 0, 1, 1, 0, 0, 0});
    vecs.push_back('{482, 1, 10, 0, 1, 1, 0, 0, 0, 0});
    vecs.push_back('{576, 0, 12, 0, 1, 1, 0, 0, 0, 0});
    vecs.push_back('{578, 1, 12, 0, 1, 1, 1, 0, 0, 0});
    vecs.push_back('{671, 23, 13, 1, 0, 1, 1, 0, 0, 0});
    vecs.push_back('{672, 0, 0,  0, 1, 1, 1, 0, 1, 0});
    vecs.push_back('{673, 0, 0,  1, 0, 1, 1, 0, 0, 0});
    vecs.push_back('{674, 1, 0,  0, 1, 1, 1, 1, 0, 'hFFAA55});

    for (int d = 0; d < 2; d++) mCnt[d] = 0;
    applyStimulus(0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      while (mCnt[0] < vecs[i].edges) tick();
      o = observe(0);
      check($sformatf("vec%0d.x", i),      o.x,    vecs[i].x);
      check($sformatf("vec%0d.y", i),      o.y,    vecs[i].y);
      check($sformatf("vec%0d.pix_en", i), o.pix,  vecs[i].pix);
      check($sformatf("vec%0d.vgaclk", i), o.vclk, vecs[i].vclk);
      check($sformatf("vec%0d.hsync", i),  o.hs,   vecs[i].hs);
      check($sformatf("vec%0d.vsync", i),  o.vs,   vecs[i].vs);
      check($sformatf("vec%0d.blank", i),  o.bl,   vecs[i].bl);
      check($sformatf("vec%0d.frame", i),  o.fs,   vecs[i].fs);
      check($sformatf("vec%0d.rgb", i),    o.rgb,  vecs[i].rgb);
    end

    // Reset in the middle of an hsync pulse must clear everything on the very next edge.
    found = 0;
    for (int i = 0; i < 2000 && found == 0; i++) begin
      tick();
      if (ifA.hsync == 1'b0 && expHs[0] == 1'b0) found = 1;
    end
    check("midreset.hsyncSeen", found, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    o = observe(0);
    check("midreset.x",      o.x,    0);
    check("midreset.y",      o.y,    0);
    check("midreset.hsync",  o.hs,   1);
    check("midreset.vsync",  o.vs,   1);
    check("midreset.blank",  o.bl,   0);
    check("midreset.rgb",    o.rgb,  0);
    check("midreset.vgaclk", o.vclk, 1);
    check("midreset.frame",  o.fs,   0);

    // Random colour changing every clk, with occasional single-clk resets, against the model.
    for (int i = 0; i < 1500; i++) begin
      applyStimulus(1);
      reset = ($urandom_range(0, 499) == 0);
      tick();
      checkOutput(0, "rndA");
      checkOutput(1, "rndB");
    end
    reset = 1'b0;

    // Coordinate-derived colour over more than a full DIV=2 frame checks output alignment.
    for (int i = 0; i < 1500; i++) begin
      applyStimulus(2);
      tick();
      checkOutput(0, "patA");
      checkOutput(1, "patB");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
